// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Data-memory slave for the core's memory stage. Each load or store request
// (mem_read_i / mem_write_i, held by the core until done_o) is captured,
// delayed by WAIT_STATES cycles, then completed against an internal
// word-organised RAM with a one-cycle done_o pulse. Byte, halfword and word
// accesses are supported, with RV32I sign/zero extension on loads.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two)
//   WAIT_STATES  extra cycles between capture and response (0..15)
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   mem_read_i   load request
//   mem_write_i  store request
//   funct3_i     access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   addr_i       byte address (wraps modulo DEPTH*4)
//   wdata_i      store data, low lanes used for sb/sh
//   rdata_o      extended load result, valid with done_o
//   done_o       one-cycle completion pulse
//   stall_o      core must hold its pipeline (request pending, not done)
//   err_o        access error, valid with done_o
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAST_WAIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [1:0]     off_q, off_d;
    logic [2:0]     f3_q, f3_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           rd_q, rd_d;
    logic           wr_q, wr_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic [31:0]    mem [DEPTH];

    logic           req;
    logic           unused_addr;

    // Fields of the transaction being completed this cycle.
    logic [AW-1:0]  cur_idx;
    logic [1:0]     cur_off;
    logic [2:0]     cur_f3;
    logic [31:0]    cur_wdata;
    logic           cur_rd, cur_wr;
    logic           cur_load, cur_store;
    logic           cur_err;
    logic           size_ok, f3_ok;

    logic [31:0]    rd_word, rd_shift, load_data;
    logic [3:0]     byte_en;
    logic [31:0]    wr_lanes;
    logic           enter_resp;
    logic           mem_we;

    assign req         = mem_read_i | mem_write_i;
    assign unused_addr = ^addr_i[31:AW+2];

    // With zero wait states a request is captured and completed on the same
    // edge, so while IDLE the live inputs describe the transaction.
    assign cur_idx   = (state_q == S_IDLE) ? addr_i[AW+1:2] : idx_q;
    assign cur_off   = (state_q == S_IDLE) ? addr_i[1:0]    : off_q;
    assign cur_f3    = (state_q == S_IDLE) ? funct3_i       : f3_q;
    assign cur_wdata = (state_q == S_IDLE) ? wdata_i        : wdata_q;
    assign cur_rd    = (state_q == S_IDLE) ? mem_read_i     : rd_q;
    assign cur_wr    = (state_q == S_IDLE) ? mem_write_i    : wr_q;

    assign cur_load  = cur_rd & ~cur_wr;
    assign cur_store = cur_wr & ~cur_rd;

    // Error decode: illegal funct3 for the operation, misalignment, or both
    // request lines high (neither a pure load nor a pure store).
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        size_ok = 1'b0;
        f3_ok   = 1'b0;
        case (cur_f3[1:0])
            2'b00:   size_ok = 1'b1;
            2'b01:   size_ok = ~cur_off[0];
            2'b10:   size_ok = (cur_off == 2'b00);
            default: size_ok = 1'b0;
        endcase
        if (cur_load) begin
            f3_ok = cur_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end else if (cur_store) begin
            f3_ok = cur_f3 inside {3'b000, 3'b001, 3'b010};
        end
    end

    assign cur_err = ~(f3_ok & size_ok);

    // Load path: select the addressed lane and extend it.
    assign rd_word  = mem[cur_idx];
    assign rd_shift = rd_word >> {cur_off, 3'b000};

    always_comb begin
        load_data = '0;
        case (cur_f3)
            3'b000:  load_data = {{24{rd_shift[7]}},  rd_shift[7:0]};
            3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, rd_shift[7:0]};
            3'b101:  load_data = {16'd0, rd_shift[15:0]};
            default: load_data = '0;
        endcase
    end

    // Store path: replicate the store data across lanes, enable only the
    // addressed ones.
    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = cur_wdata;
        case (cur_f3[1:0])
            2'b00: begin
                byte_en  = 4'b0001 << cur_off;
                wr_lanes = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                byte_en  = cur_off[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{cur_wdata[15:0]}};
            end
            2'b10: begin
                byte_en  = 4'b1111;
                wr_lanes = cur_wdata;
            end
            default: begin
                byte_en  = 4'b0000;
                wr_lanes = cur_wdata;
            end
        endcase
    end

    // Next-state and output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d   = addr_i[AW+1:2];
                    off_d   = addr_i[1:0];
                    f3_d    = funct3_i;
                    wdata_d = wdata_i;
                    rd_d    = mem_read_i;
                    wr_d    = mem_write_i;
                    cnt_d   = '0;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                // A dropped request abandons the access: no write, no pulse.
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST_WAIT) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // RESP is never followed by RESP, so this marks the completing edge.
        if (state_d == S_RESP) begin
            done_d  = 1'b1;
            err_d   = cur_err;
            rdata_d = (cur_load && !cur_err) ? load_data : '0;
        end
    end

    assign enter_resp = (state_d == S_RESP);
    assign mem_we     = enter_resp & cur_store & ~cur_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // NOTE: storage has no reset; contents survive rst_ni and map onto RAM.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[cur_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign stall_o = req & ~done_q;

endmodule
